// File: rtl/serial_bus_pkg.sv
// Shared types and width helpers for the serial bus interconnect.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CHECK,
    NACK,
    WAITDROP,
    CONNECT,
    RELEASE
  } bus_state_e;

  // Index width for a set of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold counts 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/serial_bus_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module serial_bus_rr_arbiter import serial_bus_pkg::*; #(
  parameter int N_MST = 2
) (
  input  logic [N_MST-1:0]         req,
  input  logic [$clog2(N_MST)-1:0] ptr,
  output logic [N_MST-1:0]         grant,
  output logic [$clog2(N_MST)-1:0] idx
);

  localparam int OWN_W = idx_w(N_MST);

  int   cand;
  logic found;

  // Walk requesters starting at ptr, wrapping once; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_MST; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_MST) cand = cand - N_MST;
      for (int i = 0; i < N_MST; i++) begin
        if (!found && (cand == i) && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = OWN_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/serial_bus_interconnect.sv
// N-master / N-slave serial bus with round-robin arbitration, serial slave-ID
// decode and NACK on busy or out-of-range slaves.
// Optional idle timeout in ADDR/CONNECT: define SERIAL_BUS_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus free, arbitrating among requesters
// ADDR     | shifting slave-ID bits in from the owner, MSB first
// CHECK    | one cycle: range and s_busy check on the collected slave ID
// NACK     | m_nack pulse to owner
// WAITDROP | refused or timed out; wait for owner to drop its request
// CONNECT  | lanes routed combinationally between owner and slave
// RELEASE  | one cycle: grant dropped, rr pointer advanced past owner
module serial_bus_interconnect import serial_bus_pkg::*; #(
  parameter int N_MST   = 2,
  parameter int N_SLV   = 3,
  parameter int SID_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_MST-1:0]         m_req,
  output logic [N_MST-1:0]         m_grant,
  input  logic [N_MST-1:0]         m_tx,
  input  logic [N_MST-1:0]         m_txv,
  output logic [N_MST-1:0]         m_rx,
  output logic [N_MST-1:0]         m_rxv,
  output logic [N_MST-1:0]         m_nack,
  output logic [N_SLV-1:0]         s_rx,
  output logic [N_SLV-1:0]         s_rxv,
  input  logic [N_SLV-1:0]         s_tx,
  input  logic [N_SLV-1:0]         s_txv,
  input  logic [N_SLV-1:0]         s_busy,
  output logic                     bus_busy,
  output logic [$clog2(N_MST)-1:0] owner
);

  localparam int OWN_W = idx_w(N_MST);
  localparam int CNT_W = cnt_w(SID_W);

  bus_state_e       state_q, state_d;
  logic [N_MST-1:0] grant_q, grant_d;
  logic [N_MST-1:0] nack_q, nack_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic [SID_W-1:0] sid_q, sid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_MST-1:0] arb_grant;
  logic [OWN_W-1:0] arb_idx;

  logic own_req, own_tx, own_txv;
  logic sel_stx, sel_stxv, sel_busy, sid_ok;
  logic connected;
  logic tmo;

  serial_bus_rr_arbiter #(.N_MST(N_MST)) u_arb (
    .req   (m_req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Pick out the owner's master lanes.
  always_comb begin
    own_req = 1'b0;
    own_tx  = 1'b0;
    own_txv = 1'b0;
    for (int i = 0; i < N_MST; i++) begin
      if (owner_q == OWN_W'(i)) begin
        own_req = m_req[i];
        own_tx  = m_tx[i];
        own_txv = m_txv[i];
      end
    end
  end

  // Pick out the addressed slave's lanes; sid_ok is low for IDs with no slave.
  always_comb begin
    sel_stx  = 1'b0;
    sel_stxv = 1'b0;
    sel_busy = 1'b0;
    sid_ok   = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sid_q == SID_W'(i)) begin
        sel_stx  = s_tx[i];
        sel_stxv = s_txv[i];
        sel_busy = s_busy[i];
        sid_ok   = 1'b1;
      end
    end
  end

`ifdef SERIAL_BUS_TIMEOUT_EN
  localparam int TMR_W = cnt_w(TIMEOUT);
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Idle down-counter: reloads on lane activity or outside ADDR/CONNECT.
  always_comb begin
    tmr_d = TMR_W'(TIMEOUT);
    tmo   = 1'b0;
    if ((state_q == ADDR || state_q == CONNECT) && !own_txv && !sel_stxv) begin
      tmr_d = tmr_q - 1'b1;
      tmo   = (tmr_q == TMR_W'(1));
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmr_q <= TMR_W'(TIMEOUT);
    else       tmr_q <= tmr_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    sid_d   = sid_q;
    cnt_d   = cnt_q;
    nack_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (|m_req) begin
          grant_d = arb_grant;
          owner_d = arb_idx;
          sid_d   = '0;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!own_req) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (own_txv) begin
          sid_d = SID_W'({sid_q, own_tx});
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SID_W - 1)) state_d = CHECK;
        end else if (tmo) begin
          nack_d  = grant_q;
          state_d = WAITDROP;
        end
      end
      CHECK: begin
        if (!sid_ok || sel_busy) begin
          nack_d  = grant_q;
          state_d = NACK;
        end else begin
          state_d = CONNECT;
        end
      end
      NACK: state_d = WAITDROP;
      WAITDROP: begin
        if (!own_req) begin
          grant_d = '0;
          state_d = RELEASE;
        end
      end
      CONNECT: begin
        if (!own_req) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (tmo) begin
          nack_d  = grant_q;
          state_d = WAITDROP;
        end
      end
      RELEASE: begin
        ptr_d   = (owner_q == OWN_W'(N_MST - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      nack_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      sid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      nack_q  <= nack_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      sid_q   <= sid_d;
      cnt_q   <= cnt_d;
    end
  end

  // A request drop cuts the path in the same cycle so trailing bits are not forwarded.
  assign connected = (state_q == CONNECT) && own_req;

  // Zero-latency lane routing through the registered owner/sid select.
  always_comb begin
    s_rx  = '0;
    s_rxv = '0;
    m_rx  = '0;
    m_rxv = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (connected && sid_q == SID_W'(i)) begin
        s_rx[i]  = own_tx;
        s_rxv[i] = own_txv;
      end
    end
    for (int i = 0; i < N_MST; i++) begin
      if (connected && owner_q == OWN_W'(i)) begin
        m_rx[i]  = sel_stx;
        m_rxv[i] = sel_stxv;
      end
    end
  end

  assign m_grant  = grant_q;
  assign m_nack   = nack_q;
  assign owner    = owner_q;
  assign bus_busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_bus_interconnect.sv
// Self-checking bench for serial_bus_interconnect (N_MST=2, N_SLV=3, SID_W=2, TIMEOUT=8).
module tb_serial_bus_interconnect;

  localparam int N_MST = 2;
  localparam int N_SLV = 3;
  localparam int SID_W = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [N_MST-1:0] m_req = '0, m_tx = '0, m_txv = '0;
  logic [N_MST-1:0] m_grant, m_rx, m_rxv, m_nack;
  logic [N_SLV-1:0] s_tx = '0, s_txv = '0, s_busy = '0;
  logic [N_SLV-1:0] s_rx, s_rxv;
  logic             bus_busy;
  logic [0:0]       owner;

  always #5 clk = ~clk;

  serial_bus_interconnect #(.N_MST(N_MST), .N_SLV(N_SLV), .SID_W(SID_W), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .m_req(m_req), .m_grant(m_grant), .m_tx(m_tx), .m_txv(m_txv),
    .m_rx(m_rx), .m_rxv(m_rxv), .m_nack(m_nack),
    .s_rx(s_rx), .s_rxv(s_rxv), .s_tx(s_tx), .s_txv(s_txv), .s_busy(s_busy),
    .bus_busy(bus_busy), .owner(owner)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct { int lane; logic b; } sb_t;
  sb_t q_s[$];
  sb_t q_m[$];

  typedef struct {
    int         mst;
    int         sid;
    logic [2:0] busy;
    logic       exp_nack;
    logic [7:0] md;
    logic [7:0] sd;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every active routed lane against the scoreboard heads.
  task automatic observe();
    sb_t e;
    for (int j = 0; j < N_SLV; j++) begin
      if (s_rxv[j]) begin
        if (q_s.size() == 0) check("s_rxv_unexpected", 32'(s_rxv), 32'h0);
        else begin
          e = q_s.pop_front();
          check("s_lane", j, e.lane);
          check("s_bit", 32'(s_rx[j]), 32'(e.b));
        end
      end
    end
    for (int j = 0; j < N_MST; j++) begin
      if (m_rxv[j]) begin
        if (q_m.size() == 0) check("m_rxv_unexpected", 32'(m_rxv), 32'h0);
        else begin
          e = q_m.pop_front();
          check("m_lane", j, e.lane);
          check("m_bit", 32'(m_rx[j]), 32'(e.b));
        end
      end
    end
  endtask

  // Drive one cycle of lane traffic; fwd says the bench expects it routed.
  task automatic bit_cycle(input int mst, input int slv, input logic mb, input logic mv,
                           input logic sb, input logic sv, input logic fwd);
    m_tx[mst]  = mb;
    m_txv[mst] = mv;
    s_tx[slv]  = sb;
    s_txv[slv] = sv;
    if (fwd && mv) q_s.push_back('{slv, mb});
    if (fwd && sv) q_m.push_back('{mst, sb});
    #2;
    observe();
    step();
  endtask

  task automatic send_sid(input int mst, input int sid);
    for (int b = SID_W - 1; b >= 0; b--) begin
      m_tx[mst]  = sid[b];
      m_txv[mst] = 1'b1;
      step();
    end
    m_tx  = '0;
    m_txv = '0;
  endtask

  task automatic drain_check();
    check("sb_drain_s", q_s.size(), 0);
    check("sb_drain_m", q_m.size(), 0);
    q_s.delete();
    q_m.delete();
  endtask

  task automatic run_vec(input vec_t v);
    s_busy = v.busy;
    m_req[v.mst] = 1'b1;
    #2;
    check("grant_before_edge", 32'(m_grant), 0);
    step();
    check("grant", 32'(m_grant), 1 << v.mst);
    check("owner", 32'(owner), v.mst);
    check("busy_addr", 32'(bus_busy), 1);
    send_sid(v.mst, v.sid);
    #2;
    check("nack_in_check", 32'(m_nack), 0);
    step();
    if (v.exp_nack) begin
      check("nack_pulse", 32'(m_nack), 1 << v.mst);
      bit_cycle(v.mst, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("nack_one_cycle", 32'(m_nack), 0);
      bit_cycle(v.mst, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("no_s_rxv_nack", 32'(s_rxv), 0);
      m_txv = '0;
      m_req[v.mst] = 1'b0;
      step();
    end else begin
      check("no_nack", 32'(m_nack), 0);
      for (int i = 7; i >= 0; i--)
        bit_cycle(v.mst, v.sid, v.md[i], 1'b1, v.sd[i], 1'b1, 1'b1);
      m_req[v.mst] = 1'b0;
      bit_cycle(v.mst, v.sid, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      m_txv = '0;
      s_txv = '0;
    end
    check("release_grant", 32'(m_grant), 0);
    check("release_busy", 32'(bus_busy), 1);
    step();
    check("idle_busy", 32'(bus_busy), 0);
    s_busy = '0;
    drain_check();
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    m_req = '0; m_tx = '0; m_txv = '0; s_tx = '0; s_txv = '0; s_busy = '0;
    step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    vt[0] = '{0, 2, 3'b000, 1'b0, 8'hA5, 8'h3C};
    vt[1] = '{1, 1, 3'b010, 1'b1, 8'h00, 8'h00};
    vt[2] = '{1, 3, 3'b000, 1'b1, 8'h00, 8'h00};
    vt[3] = '{0, 0, 3'b000, 1'b0, 8'h5A, 8'hF0};
    vt[4] = '{1, 1, 3'b101, 1'b0, 8'h81, 8'h7E};
    vt[5] = '{0, 2, 3'b100, 1'b1, 8'h00, 8'h00};

    // reset values
    #12;
    check("rst_grant", 32'(m_grant), 0);
    check("rst_nack", 32'(m_nack), 0);
    check("rst_busy", 32'(bus_busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_lanes", {m_rx, m_rxv, s_rx, s_rxv}, 0);
    rstn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // contention from reset: m0 then m1, m0 re-request waits for m1
    reset_pulse();
    m_req = 2'b11;
    #2;
    check("cont_grant_pre", 32'(m_grant), 0);
    step();
    check("cont_grant_m0", 32'(m_grant), 1);
    send_sid(0, 2);
    step();
    m_tx[1] = 1'b1;
    m_txv[1] = 1'b1;
    bit_cycle(0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bit_cycle(0, 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    m_req[0] = 1'b0;
    m_txv = '0; m_tx = '0; s_txv = '0;
    step();
    check("cont_release", 32'(m_grant), 0);
    m_req[0] = 1'b1;
    step();
    check("cont_idle_gap", 32'(bus_busy), 0);
    step();
    check("cont_grant_m1", 32'(m_grant), 2);
    check("cont_owner_m1", 32'(owner), 1);
    send_sid(1, 0);
    step();
    bit_cycle(1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    m_req[1] = 1'b0;
    m_txv = '0; s_txv = '0;
    step();
    step();
    step();
    check("cont_grant_m0_again", 32'(m_grant), 1);
    m_req = '0;
    step();
    step();
    check("cont_final_idle", 32'(bus_busy), 0);
    drain_check();

    // async reset mid-CONNECT after 4 data bits
    m_req[0] = 1'b1;
    step();
    send_sid(0, 2);
    step();
    for (int i = 0; i < 4; i++) bit_cycle(0, 2, i[0], 1'b1, 1'b0, 1'b0, 1'b1);
    m_tx[0] = 1'b1; m_txv[0] = 1'b1; s_tx[2] = 1'b1; s_txv[2] = 1'b1;
    #1;
    check("pre_rst_connected", 32'(s_rxv), 32'h4);
    rstn = 1'b0;
    #1;
    check("arst_grant", 32'(m_grant), 0);
    check("arst_busy", 32'(bus_busy), 0);
    check("arst_owner", 32'(owner), 0);
    check("arst_nack", 32'(m_nack), 0);
    check("arst_lanes", {m_rx, m_rxv, s_rx, s_rxv}, 0);
    drain_check();
    reset_pulse();

    // stall in CONNECT
    m_req[0] = 1'b1;
    step();
    send_sid(0, 1);
    step();
`ifdef SERIAL_BUS_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      #2;
      check("stall_no_nack", 32'(m_nack), 0);
      step();
    end
    check("timeout_nack", 32'(m_nack), 1);
    m_txv[0] = 1'b1;
    #1;
    check("timeout_disconnected", 32'(s_rxv), 0);
    step();
    check("timeout_nack_end", 32'(m_nack), 0);
    m_txv = '0;
`else
    for (int i = 0; i < 12; i++) begin
      #2;
      check("stall_no_nack", 32'(m_nack), 0);
      check("stall_grant_held", 32'(m_grant), 1);
      step();
    end
    bit_cycle(0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    m_txv = '0; s_txv = '0;
`endif
    m_req = '0;
    step();
    step();
    check("stall_final_idle", 32'(bus_busy), 0);
    drain_check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
